// File: rtl/channel_pkg.sv
// channel_pkg: shared voltage width, level type, FSM encoding and Gray helpers
package channel_pkg;
  localparam int VTH_W = 16;
  typedef logic [1:0] level_t;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic logic [1:0] gray_of(input level_t l);
    return {l[1], l[1] ^ l[0]};
  endfunction
  function automatic logic [1:0] gray_bit_errs(input level_t a, input level_t b);
    logic [1:0] x;
    x = gray_of(a) ^ gray_of(b);
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction
endpackage

// File: rtl/level_align_fifo.sv
// level_align_fifo: sync FIFO of written levels, same-cycle push/pop at full and empty
module level_align_fifo
  import channel_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  level_t wr_data,
  output level_t rd_data,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  level_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_ptr_q == rd_ptr_q;
    full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    rd_data = mem_q[rd_ptr_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/vth_read_detector.sv
// vth_read_detector: hard-decides channel voltages against three refs and counts symbol/Gray bit errors per frame
module vth_read_detector #(
  parameter int VTH_W      = channel_pkg::VTH_W,
  parameter int FIFO_DEPTH = 64,
  parameter int FRAME_LEN  = 1024,
  parameter int CNT_W      = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [VTH_W-1:0] ref_v1,
  input  logic [VTH_W-1:0] ref_v2,
  input  logic [VTH_W-1:0] ref_v3,
  input  logic [1:0]       level_in,
  input  logic             level_valid,
  input  logic [VTH_W-1:0] vth_in,
  input  logic             vth_valid,
  output logic [1:0]       det_level,
  output logic             det_valid,
  output logic             det_err,
  output logic [CNT_W-1:0] sym_err_cnt,
  output logic [CNT_W-1:0] bit_err_cnt,
  output logic             busy,
  output logic             frame_done,
  output logic             fifo_ovf,
  output logic             fifo_unf
);
  import channel_pkg::*;
  localparam int SW = $clog2(FRAME_LEN + 1);
  localparam int XW = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  state_t state_q, state_d;
  logic [VTH_W-1:0] ref1_q, ref1_d, ref2_q, ref2_d, ref3_q, ref3_d;
  level_t det, wr_level, det_level_q, det_level_d;
  logic det_valid_q, det_valid_d, det_err_q, det_err_d;
  logic [1:0] det_bits_q, det_bits_d;
  logic [SW-1:0] smp_q, smp_d;
  logic [CNT_W-1:0] sym_q, sym_d, bit_q, bit_d;
  logic [XW-1:0] sym_sum, bit_sum;
  logic frame_done_q, frame_done_d, ovf_q, ovf_d, unf_q, unf_d;
  logic fifo_full, fifo_empty, take_start, count, last;
  level_align_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (level_valid),
    .pop    (vth_valid),
    .wr_data(level_in),
    .rd_data(wr_level),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  // Counting is driven by the registered det_valid, so the frame closes on the FRAME_LEN-th counted sample
  always_comb begin
    take_start = start && state_q != RUN;
    count = state_q == RUN && det_valid_q;
    last = count && smp_q == SW'(FRAME_LEN - 1);
    state_d = take_start ? RUN : last ? DONE : state_q;
  end
  always_comb begin
    busy = state_q == RUN;
  end
  always_comb begin
    det = 2'(vth_in >= ref1_q) + 2'(vth_in >= ref2_q) + 2'(vth_in >= ref3_q);
    det_valid_d = vth_valid && !fifo_empty;
    det_level_d = det_valid_d ? det : det_level_q;
    det_err_d = det_valid_d ? det != wr_level : det_err_q;
    det_bits_d = det_valid_d ? gray_bit_errs(det, wr_level) : det_bits_q;
    sym_sum = {1'b0, sym_q} + XW'(det_err_q);
    bit_sum = {1'b0, bit_q} + XW'(det_bits_q);
    sym_d = take_start ? '0 : count ? (sym_sum[CNT_W] ? CNT_MAX : sym_sum[CNT_W-1:0]) : sym_q;
    bit_d = take_start ? '0 : count ? (bit_sum[CNT_W] ? CNT_MAX : bit_sum[CNT_W-1:0]) : bit_q;
    smp_d = take_start ? '0 : count ? smp_q + SW'(1) : smp_q;
    frame_done_d = last;
    ovf_d = (!take_start && ovf_q) || (level_valid && fifo_full && !det_valid_d);
    unf_d = (!take_start && unf_q) || (vth_valid && fifo_empty);
    ref1_d = take_start ? ref_v1 : ref1_q;
    ref2_d = take_start ? ref_v2 : ref2_q;
    ref3_d = take_start ? ref_v3 : ref3_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ref1_q <= '0;
      ref2_q <= '0;
      ref3_q <= '0;
      det_level_q <= '0;
      det_valid_q <= 1'b0;
      det_err_q <= 1'b0;
      det_bits_q <= '0;
      smp_q <= '0;
      sym_q <= '0;
      bit_q <= '0;
      frame_done_q <= 1'b0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ref1_q <= ref1_d;
      ref2_q <= ref2_d;
      ref3_q <= ref3_d;
      det_level_q <= det_level_d;
      det_valid_q <= det_valid_d;
      det_err_q <= det_err_d;
      det_bits_q <= det_bits_d;
      smp_q <= smp_d;
      sym_q <= sym_d;
      bit_q <= bit_d;
      frame_done_q <= frame_done_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_comb begin
    det_level = det_level_q;
    det_valid = det_valid_q;
    det_err = det_err_q;
    sym_err_cnt = sym_q;
    bit_err_cnt = bit_q;
    frame_done = frame_done_q;
    fifo_ovf = ovf_q;
    fifo_unf = unf_q;
  end
endmodule

// File: tb/tb_vth_read_detector.sv
// tb_vth_read_detector: directed scoreboard bench for the read detector
module tb_vth_read_detector;
  localparam int FL = 8;
  localparam int DEPTH = 64;
  localparam int CW = 20;
  logic clk = 1'b0;
  logic reset, start, level_valid, vth_valid;
  logic [15:0] ref_v1, ref_v2, ref_v3, vth_in;
  logic [1:0] level_in, det_level;
  logic det_valid, det_err, busy, frame_done, fifo_ovf, fifo_unf;
  logic [CW-1:0] sym_err_cnt, bit_err_cnt;
  int errors = 0, checks = 0;
  logic [1:0] mfifo [$];
  logic [2:0] exp_q [$];
  logic [15:0] r1 = '0, r2 = '0, r3 = '0;
  logic [1:0] gtab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
  bit mrun = 1'b0;
  int mn = 0, msym = 0, mbit = 0, fd_pulses = 0;
  int t1v [4] = '{999, 1000, 2000, 3999};
  int t3v [4] = '{3500, 2500, 1500, 500};
  int t3l [4] = '{1, 1, 1, 3};
  always #5 clk = ~clk;
  vth_read_detector #(.VTH_W(16), .FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ref_v1     (ref_v1),
    .ref_v2     (ref_v2),
    .ref_v3     (ref_v3),
    .level_in   (level_in),
    .level_valid(level_valid),
    .vth_in     (vth_in),
    .vth_valid  (vth_valid),
    .det_level  (det_level),
    .det_valid  (det_valid),
    .det_err    (det_err),
    .sym_err_cnt(sym_err_cnt),
    .bit_err_cnt(bit_err_cnt),
    .busy       (busy),
    .frame_done (frame_done),
    .fifo_ovf   (fifo_ovf),
    .fifo_unf   (fifo_unf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cycle(input logic st, input logic lv_v, input logic [1:0] lv, input logic vv, input logic [15:0] vt);
    bit pre_empty, pre_full, popd;
    logic [1:0] wr, d;
    logic [2:0] e;
    pre_empty = mfifo.size() == 0;
    pre_full = mfifo.size() == DEPTH;
    if (st && !mrun) begin
      mrun = 1'b1; mn = 0; msym = 0; mbit = 0;
      r1 = ref_v1; r2 = ref_v2; r3 = ref_v3;
    end
    popd = vv && !pre_empty;
    if (popd) begin
      wr = mfifo.pop_front();
      d = 2'(vt >= r1) + 2'(vt >= r2) + 2'(vt >= r3);
      exp_q.push_back({d != wr, d});
      if (mrun) begin
        msym += int'(d != wr);
        mbit += $countones(gtab[d] ^ gtab[wr]);
        mn++;
        if (mn == FL) mrun = 1'b0;
      end
    end
    if (lv_v && !(pre_full && !popd)) mfifo.push_back(lv);
    start = st; level_valid = lv_v; level_in = lv; vth_valid = vv; vth_in = vt;
    @(posedge clk); #1;
    start = 1'b0; level_valid = 1'b0; vth_valid = 1'b0;
    fd_pulses += int'(frame_done);
    if (det_valid) begin
      if (exp_q.size() == 0) chk("unexpected_det", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("det_level", 32'(det_level), 32'(e[1:0]));
        chk("det_err", 32'(det_err), 32'(e[2]));
      end
    end else if (exp_q.size() != 0) begin
      chk("missing_det", 0, 1);
      void'(exp_q.pop_front());
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 16'd0);
  endtask
  initial begin
    start = 1'b0; level_valid = 1'b0; vth_valid = 1'b0; level_in = '0; vth_in = '0;
    ref_v1 = '0; ref_v2 = '0; ref_v3 = '0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_det_valid", 32'(det_valid), 0);
    chk("rst_det_level", 32'(det_level), 0);
    chk("rst_det_err", 32'(det_err), 0);
    chk("rst_sym", 32'(sym_err_cnt), 0);
    chk("rst_bit", 32'(bit_err_cnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_ovf", 32'(fifo_ovf), 0);
    chk("rst_unf", 32'(fifo_unf), 0);
    // decision thresholds and ties, then Gray bit-error weights, in one frame
    ref_v1 = 16'd1000; ref_v2 = 16'd2000; ref_v3 = 16'd3000;
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
    chk("t1_busy", 32'(busy), 1);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'(i), 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'(t1v[i]));
    idle(2);
    chk("t1_sym", 32'(sym_err_cnt), 0);
    chk("t1_bit", 32'(bit_err_cnt), 0);
    fd_pulses = 0;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 2'(t3l[i]), 1'b0, 16'd0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'(t3v[i]));
    idle(4);
    chk("t3_frame_done", fd_pulses, 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_sym", 32'(sym_err_cnt), 3);
    chk("t3_bit", 32'(bit_err_cnt), 4);
    // full frame of written 0 read back as level 2
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
    chk("t2_start_clear", 32'(sym_err_cnt), 0);
    fd_pulses = 0;
    for (int i = 0; i < FL; i++) cycle(1'b0, 1'b1, 2'd0, 1'b0, 16'd0);
    for (int i = 0; i < FL; i++) cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'd2500);
    idle(4);
    chk("t2_frame_done", fd_pulses, 1);
    chk("t2_sym", 32'(sym_err_cnt), 8);
    chk("t2_bit", 32'(bit_err_cnt), 16);
    chk("t2_ovf", 32'(fifo_ovf), 0);
    chk("t2_unf", 32'(fifo_unf), 0);
    // underflow: read with no written level queued
    cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'd1234);
    chk("t5_unf", 32'(fifo_unf), 1);
    idle(2);
    chk("t5_sym", 32'(sym_err_cnt), 8);
    chk("t5_bit", 32'(bit_err_cnt), 16);
    // overflow with unordered refs; 65th push dropped, 64 pop in order
    ref_v1 = 16'd3000; ref_v2 = 16'd1000; ref_v3 = 16'd2000;
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
    chk("t4_unf_cleared", 32'(fifo_unf), 0);
    fd_pulses = 0;
    for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 2'(i * 3 + 1), 1'b0, 16'd0);
    chk("t4_ovf", 32'(fifo_ovf), 1);
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'($urandom_range(0, 4000)));
    idle(4);
    chk("t4_no_unf", 32'(fifo_unf), 0);
    chk("t4_frame_done", fd_pulses, 1);
    chk("t4_sym", 32'(sym_err_cnt), 32'(msym));
    chk("t4_bit", 32'(bit_err_cnt), 32'(mbit));
    cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'd10);
    chk("t4_drained_unf", 32'(fifo_unf), 1);
    // reset in the middle of a frame
    ref_v1 = 16'd1000; ref_v2 = 16'd2000; ref_v3 = 16'd3000;
    cycle(1'b1, 1'b0, 2'd0, 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 2'(i), 1'b0, 16'd0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 2'd0, 1'b1, 16'(i * 800));
    idle(2);
    chk("t6_busy_mid", 32'(busy), 1);
    chk("t6_sym_mid", 32'(sym_err_cnt), 32'(msym));
    chk("t6_bit_mid", 32'(bit_err_cnt), 32'(mbit));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mfifo.delete(); exp_q.delete(); mrun = 1'b0;
    chk("t6_busy", 32'(busy), 0);
    chk("t6_sym", 32'(sym_err_cnt), 0);
    chk("t6_bit", 32'(bit_err_cnt), 0);
    chk("t6_det_valid", 32'(det_valid), 0);
    chk("t6_unf", 32'(fifo_unf), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
